// File: rtl/adder_pkg.sv
// Shared types and defaults for the pipelined add/subtract unit.
//   op_e         : operation select carried with each operand beat
//   slice_count  : number of pipeline stages for a given width/slice
//   ADDER_W/ADDER_SLICE : default operand width and bits per stage
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned ADDER_W     = 32;
  localparam int unsigned ADDER_SLICE = 8;

  // Guarded so that a zero slice reaches the elaboration check instead of dividing by zero.
  function automatic int unsigned slice_count(int unsigned w, int unsigned slice);
    return (slice == 0) ? 1 : w / slice;
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
//   in_*  : operand beat (valid/ready), operands A/B, carry-in, op
//   out_* : result beat (valid/ready), sum, carry-out, signed overflow
// Modports: master = upstream source + downstream sink, slave = the adder.
interface pipelined_addsub_if
  import adder_pkg::*;
#(
  parameter int unsigned W = ADDER_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  op_e          in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/carry_slice.sv
// Combinational SLICE-bit adder used once per pipeline stage.
//   a, b, cin : slice operands and incoming carry
//   sum       : slice sum
//   cout      : carry out of the slice MSB
//   c_msb     : carry into the slice MSB (for signed overflow)
module carry_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    sum   = full[SLICE-1:0];
    cout  = full[SLICE];
    // Carry into the MSB recovered from the MSB's own sum bit.
    c_msb = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined W-bit adder/subtractor: one SLICE-bit chunk per stage, carry
// registered between stages, latency W/SLICE, one beat per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : in_valid/in_ready/in_a/in_b/in_cin/in_op operand stream,
//                out_valid/out_ready/out_sum/out_cout/out_ovf result stream
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int unsigned W     = ADDER_W,
  parameter int unsigned SLICE = ADDER_SLICE
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave io
);

  localparam int unsigned STAGES = slice_count(W, SLICE);

  if (SLICE < 1) begin : g_bad_slice
    $error("pipelined_addsub: SLICE must be at least 1");
  end else if (W % SLICE != 0) begin : g_bad_width
    $error("pipelined_addsub: W must be a multiple of SLICE");
  end

  // Pipeline taps: index 0 is the accepted input, index k+1 is stage k's registers.
  logic         v_tap [STAGES+1];
  logic         c_tap [STAGES+1];
  logic [W-1:0] a_tap [STAGES+1];
  logic [W-1:0] b_tap [STAGES+1];
  logic [W-1:0] s_tap [STAGES+1];
  logic         msb_tap [STAGES];

  logic         adv;
  logic [W-1:0] b_in;
  logic         msb_q, msb_d;

  always_comb begin
    b_in = (io.in_op == OP_SUB) ? ~io.in_b : io.in_b;
  end

  assign v_tap[0] = io.in_valid;
  assign a_tap[0] = io.in_a;
  assign b_tap[0] = b_in;
  assign s_tap[0] = '0;
  assign c_tap[0] = io.in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_q, valid_d;
    logic             c_q, c_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_msb;

    carry_slice #(.SLICE(SLICE)) u_slice (
      .a     (a_tap[k][k*SLICE +: SLICE]),
      .b     (b_tap[k][k*SLICE +: SLICE]),
      .cin   (c_tap[k]),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_msb)
    );

    // A and B' travel whole so later slices stay aligned with their beat;
    // finished lower sum slices are carried along in sum_q.
    always_comb begin
      valid_d = valid_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      if (adv) begin
        valid_d                    = v_tap[k];
        c_d                        = slice_cout;
        a_d                        = a_tap[k];
        b_d                        = b_tap[k];
        sum_d                      = s_tap[k];
        sum_d[k*SLICE +: SLICE]    = slice_sum;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        c_q     <= c_d;
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
      end
    end

    assign v_tap[k+1]  = valid_q;
    assign c_tap[k+1]  = c_q;
    assign a_tap[k+1]  = a_q;
    assign b_tap[k+1]  = b_q;
    assign s_tap[k+1]  = sum_q;
    assign msb_tap[k]  = slice_msb;
  end

  // Whole pipeline advances together; a stalled output freezes every stage.
  always_comb begin
    adv   = !v_tap[STAGES] | io.out_ready;
    msb_d = adv ? msb_tap[STAGES-1] : msb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_q <= 1'b0;
    end else begin
      msb_q <= msb_d;
    end
  end

  always_comb begin
    io.in_ready  = adv;
    io.out_valid = v_tap[STAGES];
    io.out_sum   = s_tap[STAGES];
    io.out_cout  = c_tap[STAGES];
    io.out_ovf   = c_tap[STAGES] ^ msb_q;
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at W=32, SLICE=8 (latency 4).
module tb_pipelined_addsub;
  import adder_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned SLICE = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pipelined_addsub_if #(.W(W)) io ();

  pipelined_addsub #(.W(W), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input op_e op);
    io.in_valid = v;
    io.in_a     = a;
    io.in_b     = b;
    io.in_cin   = cin;
    io.in_op    = op;
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input op_e op);
    logic [31:0] bp;
    logic [32:0] full;
    logic        ovf;
    bp   = (op == OP_SUB) ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {32'd0, cin};
    ovf  = (a[31] == bp[31]) && (full[31] != a[31]);
    return {ovf, full[32], full[31:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    io.out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, OP_ADD);
    #2;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", io.out_valid); end
    checks++; if (io.out_sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h exp 00000000", io.out_sum); end
    checks++; if (io.out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b exp 0", io.out_cout); end
    checks++; if (io.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", io.out_ovf); end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", io.in_ready); end
    step(); step();
    #3 rst_n = 1'b1;
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b exp 0", io.out_valid); end
  endtask

  task automatic test_carry_ripple();
    logic [33:0] got;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) drive(1'b0, '0, '0, 1'b0, OP_ADD);
      got = {io.out_ovf, io.out_cout, io.out_sum};
      if (i == 3) begin
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL ripple_valid: got %b exp 1", io.out_valid); end
        checks++; if (got !== 34'h1_0000_0000) begin errors++; $display("FAIL ripple_result: got %h exp %h", got, 34'h1_0000_0000); end
      end else begin
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL ripple_idle_%0d: got %b exp 0", i, io.out_valid); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [33:0] got;
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB);
    step();
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
    step();
    drive(1'b0, '0, '0, 1'b0, OP_ADD);
    step(); step();
    got = {io.out_ovf, io.out_cout, io.out_sum};
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL sub_ovf_valid: got %b exp 1", io.out_valid); end
    checks++; if (got !== 34'h3_7FFF_FFFF) begin errors++; $display("FAIL sub_ovf_result: got %h exp %h", got, 34'h3_7FFF_FFFF); end
    step();
    got = {io.out_ovf, io.out_cout, io.out_sum};
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL add_ovf_valid: got %b exp 1", io.out_valid); end
    checks++; if (got !== 34'h2_8000_0000) begin errors++; $display("FAIL add_ovf_result: got %h exp %h", got, 34'h2_8000_0000); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b exp 0", io.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [16];
    logic [31:0] b [16];
    logic        c [16];
    op_e         op [16];
    logic [33:0] exp_r [16];
    logic [33:0] got;
    for (int i = 0; i < 16; i++) begin
      a[i]  = $urandom;
      b[i]  = $urandom;
      c[i]  = 1'($urandom_range(0, 1));
      op[i] = op_e'($urandom_range(0, 1));
      exp_r[i] = model(a[i], b[i], c[i], op[i]);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 16) begin
        drive(1'b1, a[cyc], b[cyc], c[cyc], op[cyc]);
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b exp 1", cyc, io.in_ready); end
      end else begin
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
      end
      step();
      got = {io.out_ovf, io.out_cout, io.out_sum};
      if (cyc >= 3 && cyc < 19) begin
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b exp 1", cyc - 3, io.out_valid); end
        checks++; if (got !== exp_r[cyc-3]) begin errors++; $display("FAIL b2b_result_%0d: got %h exp %h", cyc - 3, got, exp_r[cyc-3]); end
      end else begin
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d: got %b exp 0", cyc, io.out_valid); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic        c [8];
    op_e         op [8];
    logic [33:0] exp_r [8];
    logic [33:0] got;
    for (int i = 0; i < 8; i++) begin
      a[i]  = $urandom;
      b[i]  = $urandom;
      c[i]  = 1'($urandom_range(0, 1));
      op[i] = op_e'($urandom_range(0, 1));
      exp_r[i] = model(a[i], b[i], c[i], op[i]);
    end
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(1'b1, a[cyc], b[cyc], c[cyc], op[cyc]);
      step();
    end
    got = {io.out_ovf, io.out_cout, io.out_sum};
    checks++; if (got !== exp_r[0] || io.out_valid !== 1'b1) begin errors++; $display("FAIL stall_head: got %h v=%b exp %h v=1", got, io.out_valid, exp_r[0]); end
    io.out_ready = 1'b0;
    drive(1'b1, a[4], b[4], c[4], op[4]);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b exp 0", i, io.in_ready); end
      step();
      got = {io.out_ovf, io.out_cout, io.out_sum};
      checks++; if (io.out_valid !== 1'b1 || got !== exp_r[0]) begin errors++; $display("FAIL stall_hold_%0d: got %h v=%b exp %h v=1", i, got, io.out_valid, exp_r[0]); end
    end
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 4) drive(1'b1, a[cyc+4], b[cyc+4], c[cyc+4], op[cyc+4]);
      else         drive(1'b0, '0, '0, 1'b0, OP_ADD);
      #1;
      got = {io.out_ovf, io.out_cout, io.out_sum};
      if (cyc < 8) begin
        checks++; if (io.out_valid !== 1'b1 || got !== exp_r[cyc]) begin errors++; $display("FAIL stall_drain_%0d: got %h v=%b exp %h v=1", cyc, got, io.out_valid, exp_r[cyc]); end
      end else begin
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra_%0d: got %b exp 0", cyc, io.out_valid); end
      end
      step();
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] a [4]   = '{32'h0000_0005, 32'h1234_5678, 32'h0000_0010, 32'h0000_00FF};
    logic [31:0] b [4]   = '{32'h0000_0007, 32'h1111_1111, 32'h0000_0010, 32'h0000_0001};
    logic        c [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    op_e         op [4]  = '{OP_SUB, OP_ADD, OP_SUB, OP_ADD};
    logic [33:0] exp_r [4] = '{34'h0_FFFF_FFFE, 34'h0_2345_6789, 34'h1_0000_0000, 34'h0_0000_0101};
    logic [33:0] got;
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (cyc % 2 == 0 && cyc / 2 < 4) drive(1'b1, a[cyc/2], b[cyc/2], c[cyc/2], op[cyc/2]);
      else                             drive(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, OP_SUB);
      step();
      got = {io.out_ovf, io.out_cout, io.out_sum};
      if (cyc >= 3 && (cyc - 3) % 2 == 0 && (cyc - 3) / 2 < 4) begin
        checks++; if (io.out_valid !== 1'b1 || got !== exp_r[(cyc-3)/2]) begin errors++; $display("FAIL bubble_result_%0d: got %h v=%b exp %h v=1", (cyc - 3) / 2, got, io.out_valid, exp_r[(cyc-3)/2]); end
      end else begin
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_gap_%0d: got %b exp 0", cyc, io.out_valid); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [33:0] got;
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(1'b1, 32'(cyc + 1), 32'h0000_0001, 1'b0, OP_ADD);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, OP_ADD);
    got = {io.out_ovf, io.out_cout, io.out_sum};
    checks++; if (io.out_valid !== 1'b1 || got !== 34'h0_0000_0002) begin errors++; $display("FAIL midrst_head: got %h v=%b exp %h v=1", got, io.out_valid, 34'h0_0000_0002); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_drop: got %b exp 0", io.out_valid); end
    checks++; if (io.out_sum !== 32'h0) begin errors++; $display("FAIL midrst_sum_clear: got %h exp 00000000", io.out_sum); end
    @(posedge clk);
    #4 rst_n = 1'b1;
    drive(1'b1, 32'h0000_00FF, 32'h0000_0F01, 1'b0, OP_ADD);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) drive(1'b0, '0, '0, 1'b0, OP_ADD);
      got = {io.out_ovf, io.out_cout, io.out_sum};
      if (i == 3) begin
        checks++; if (io.out_valid !== 1'b1 || got !== 34'h0_0000_1000) begin errors++; $display("FAIL midrst_new_beat: got %h v=%b exp %h v=1", got, io.out_valid, 34'h0_0000_1000); end
      end else begin
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_%0d: got %b exp 0", i, io.out_valid); end
      end
    end
  endtask

  initial begin
    void'($urandom(32'd12345));
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
